// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor front end.
// Optional macro INERT_AZ_EN extends each burst to include the az word.
package inert_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_CFG0,
        ST_CFG1,
        ST_CFG2,
        ST_CFG3,
        ST_WAIT_INT,
        ST_RD,
        ST_COMMIT
    } state_t;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_FRONT,
        SPI_XFER,
        SPI_FIN,
        SPI_BACK
    } spi_state_t;

    // Data-ready interrupt, accel 208 Hz, gyro 208 Hz, register rounding.
    localparam logic [15:0] CFG_CMD [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

    localparam logic [7:0] RD_BASE = 8'hA2;
    localparam int         IDX_W   = 4;

`ifdef INERT_AZ_EN
    localparam int RD_COUNT = 12;
`else
    localparam int RD_COUNT = 10;
`endif

    function automatic logic [15:0] rd_cmd(input logic [IDX_W-1:0] idx);
        rd_cmd = {RD_BASE + 8'(idx), 8'h00};
    endfunction

endpackage

// File: rtl/inert_intf_seq_spi_txn.sv
// 16-bit full-duplex SPI mode-3 master for one transaction per wrt pulse.
// Unaffected by INERT_AZ_EN.
module spi_txn
    import inert_pkg::*;
#(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        miso,
    output logic        ss_n,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [7:0]  rd_data
);

    localparam int             CW      = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCLK_DIV - 1);

    spi_state_t  st_q, st_d;
    logic [CW-1:0] cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] shreg;
    logic        miso_bit;
    logic        tick;

    assign tick    = (cnt == CNT_MAX);
    assign mosi    = ss_n ? 1'b0 : shreg[15];
    assign rd_data = shreg[7:0];

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            SPI_IDLE:  if (wrt) st_d = SPI_FRONT;
            SPI_FRONT: if (tick) st_d = SPI_XFER;
            SPI_XFER:  if (tick && !sclk && bit_cnt == 4'd15) st_d = SPI_FIN;
            SPI_FIN:   st_d = SPI_BACK;
            SPI_BACK:  if (tick) st_d = SPI_IDLE;
            default:   st_d = SPI_IDLE;
        endcase
    end

    // Shifting happens on SCLK falls; the bit sampled on each rise is parked
    // in miso_bit so MOSI never changes on the edge the slave samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= SPI_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            miso_bit <= 1'b0;
            sclk     <= 1'b1;
            ss_n     <= 1'b1;
            done     <= 1'b0;
        end else begin
            st_q <= st_d;
            done <= (st_q == SPI_FIN);
            unique case (st_q)
                SPI_IDLE: begin
                    cnt <= '0;
                    if (wrt) begin
                        shreg   <= cmd;
                        ss_n    <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                SPI_FRONT: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) sclk <= 1'b0;
                end
                SPI_XFER: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        if (sclk) begin
                            sclk  <= 1'b0;
                            shreg <= {shreg[14:0], miso_bit};
                        end else begin
                            sclk     <= 1'b1;
                            miso_bit <= miso;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                end
                SPI_FIN: begin
                    cnt   <= '0;
                    shreg <= {shreg[14:0], miso_bit};
                end
                SPI_BACK: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) ss_n <= 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/inert_intf_seq.sv
// Sensor init + data-ready burst reader feeding the inertial integrator.
// Define INERT_AZ_EN to add the az output and two extra burst reads.
module inert_intf_seq
    import inert_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int SCLK_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INT,
    input  logic               MISO,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI,
    output logic               vld,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] roll_rt,
    output logic signed [15:0] yaw_rt,
    output logic signed [15:0] ax,
`ifdef INERT_AZ_EN
    output logic signed [15:0] ay,
    output logic signed [15:0] az
`else
    output logic signed [15:0] ay
`endif
);

    localparam int SW = FAST_SIM ? 9 : 16;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_cnt;
    logic             int_meta, int_sync;
    logic             issued, issue_ok;
    logic             wrt, done;
    logic [15:0]      cmd;
    logic [7:0]       rd_data;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_last;
    logic [7:0]       hold     [RD_COUNT];
    logic [7:0]       hold_nxt [RD_COUNT];

    spi_txn #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .miso    (MISO),
        .ss_n    (SS_n),
        .sclk    (SCLK),
        .mosi    (MOSI),
        .done    (done),
        .rd_data (rd_data)
    );

    assign issue_ok = !issued && SS_n;
    assign rd_last  = (rd_idx == IDX_W'(RD_COUNT - 1));
    assign vld      = (state_q == ST_COMMIT);

    always_comb begin
        state_d = state_q;
        wrt     = 1'b0;
        cmd     = 16'h0000;
        unique case (state_q)
            ST_SETTLE:   if (&settle_cnt) state_d = ST_CFG0;
            ST_CFG0: begin
                cmd = CFG_CMD[0];
                wrt = issue_ok;
                if (done) state_d = ST_CFG1;
            end
            ST_CFG1: begin
                cmd = CFG_CMD[1];
                wrt = issue_ok;
                if (done) state_d = ST_CFG2;
            end
            ST_CFG2: begin
                cmd = CFG_CMD[2];
                wrt = issue_ok;
                if (done) state_d = ST_CFG3;
            end
            ST_CFG3: begin
                cmd = CFG_CMD[3];
                wrt = issue_ok;
                if (done) state_d = ST_WAIT_INT;
            end
            ST_WAIT_INT: if (int_sync) state_d = ST_RD;
            ST_RD: begin
                cmd = rd_cmd(rd_idx);
                wrt = issue_ok;
                if (done && rd_last) state_d = ST_COMMIT;
            end
            ST_COMMIT:   state_d = ST_WAIT_INT;
            default:     state_d = ST_SETTLE;
        endcase
    end

    // The byte arriving with the final done is folded in here so the commit
    // can happen on the same edge, one clock after that done.
    always_comb begin
        for (int i = 0; i < RD_COUNT; i++) hold_nxt[i] = hold[i];
        if (state_q == ST_RD && done) hold_nxt[rd_idx] = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SETTLE;
            settle_cnt <= '0;
            int_meta   <= 1'b0;
            int_sync   <= 1'b0;
            issued     <= 1'b0;
            rd_idx     <= '0;
            hold       <= '{default: 8'h00};
            ptch_rt    <= '0;
            roll_rt    <= '0;
            yaw_rt     <= '0;
            ax         <= '0;
            ay         <= '0;
`ifdef INERT_AZ_EN
            az         <= '0;
`endif
        end else begin
            state_q  <= state_d;
            int_meta <= INT;
            int_sync <= int_meta;
            hold     <= hold_nxt;
            if (state_q == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
            if (wrt) issued <= 1'b1;
            else if (done) issued <= 1'b0;
            if (state_q == ST_WAIT_INT) rd_idx <= '0;
            else if (state_q == ST_RD && done) rd_idx <= rd_idx + 1'b1;
            if (state_q == ST_RD && done && rd_last) begin
                ptch_rt <= {hold_nxt[1], hold_nxt[0]};
                roll_rt <= {hold_nxt[3], hold_nxt[2]};
                yaw_rt  <= {hold_nxt[5], hold_nxt[4]};
                ax      <= {hold_nxt[7], hold_nxt[6]};
                ay      <= {hold_nxt[9], hold_nxt[8]};
`ifdef INERT_AZ_EN
                az      <= {hold_nxt[11], hold_nxt[10]};
`endif
            end
        end
    end

endmodule

// File: tb/tb_inert_intf_seq.sv
// Bench for inert_intf_seq with an SPI slave model of the inertial sensor.
// Define INERT_AZ_EN to exercise the az extension.
module tb_inert_intf_seq;

    localparam int SCLK_DIV = 8;
`ifdef INERT_AZ_EN
    localparam int NRD = 12;
`else
    localparam int NRD = 10;
`endif

    typedef struct {
        logic [15:0] ptch, roll, yaw, ax, ay, az;
    } sample_t;

    typedef struct {
        sample_t sensor;
        sample_t expect_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic INT = 1'b0;
    logic MISO = 1'b0;
    logic SS_n, SCLK, MOSI, vld;
    logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
`ifdef INERT_AZ_EN
    logic signed [15:0] az;
`endif

    always #5 clk = ~clk;

    inert_intf_seq #(.FAST_SIM(1'b1), .SCLK_DIV(SCLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .roll_rt (roll_rt),
        .yaw_rt  (yaw_rt),
        .ax      (ax),
`ifdef INERT_AZ_EN
        .ay      (ay),
        .az      (az)
`else
        .ay      (ay)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    sample_t     exp_out_q[$];
    vec_t        vecs[4];
    logic [7:0]  mem[256];

    int txn_cnt  = 0;
    int ss_falls = 0;
    int vld_cnt  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pack_s(input sample_t s);
`ifdef INERT_AZ_EN
        pack_s = {s.ptch, s.roll, s.yaw, s.ax, s.ay, s.az};
`else
        pack_s = {s.ptch, s.roll, s.yaw, s.ax, s.ay, 16'h0000};
`endif
    endfunction

    function automatic logic [95:0] dut_out();
`ifdef INERT_AZ_EN
        dut_out = {ptch_rt, roll_rt, yaw_rt, ax, ay, az};
`else
        dut_out = {ptch_rt, roll_rt, yaw_rt, ax, ay, 16'h0000};
`endif
    endfunction

    // ---------------- SPI slave model ----------------
    logic [15:0] rx = 16'h0;
    logic [7:0]  rd_byte = 8'h00;
    int          nbits = 0;
    int          nfalls = 0;

    always @(negedge SS_n) begin
        rx = 16'h0;
        nbits = 0;
        nfalls = 0;
        MISO = 1'b0;
        ss_falls++;
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0) begin
            if (nfalls == 8) rd_byte = mem[rx[7:0]];
            MISO = (nfalls >= 8) ? rd_byte[15-nfalls] : 1'b0;
            nfalls++;
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            rx = {rx[14:0], MOSI};
            nbits++;
        end
    end

    always @(posedge SS_n) begin
        if (nbits == 16) begin
            txn_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spi_unexpected: got %h expected none", rx);
            end else begin
                chk("spi_cmd", 96'(rx), 96'(exp_q.pop_front()));
            end
        end
        nbits = 0;
    end

    // ---------------- output scoreboard ----------------
    sample_t last_out = '{default: 16'h0};
    logic    vld_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            last_out = '{default: 16'h0};
        end else if (vld === 1'b1) begin
            vld_cnt++;
            if (exp_out_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL vld_unexpected: got %h expected no pulse", dut_out());
            end else begin
                last_out = exp_out_q.pop_front();
                chk("commit_data", dut_out(), pack_s(last_out));
            end
        end else begin
            chk("hold_between", dut_out(), pack_s(last_out));
        end
        if (vld_prev) chk("vld_width", 96'(vld), 96'(0));
        vld_prev = vld;
    end

    // vld follows the last done by one clock; SS_n then rises SCLK_DIV-1 clocks later.
    always begin
        int c;
        do @(negedge clk); while (vld !== 1'b1);
        c = 0;
        while (SS_n !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk_int("vld_to_ss_rise", c, SCLK_DIV - 1);
    end

    // ---------------- driver tasks ----------------
    task automatic load_mem(input sample_t s);
        mem[8'hA2] = s.ptch[7:0]; mem[8'hA3] = s.ptch[15:8];
        mem[8'hA4] = s.roll[7:0]; mem[8'hA5] = s.roll[15:8];
        mem[8'hA6] = s.yaw[7:0];  mem[8'hA7] = s.yaw[15:8];
        mem[8'hA8] = s.ax[7:0];   mem[8'hA9] = s.ax[15:8];
        mem[8'hAA] = s.ay[7:0];   mem[8'hAB] = s.ay[15:8];
        mem[8'hAC] = s.az[7:0];   mem[8'hAD] = s.az[15:8];
    endtask

    task automatic push_cmds(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({8'(8'hA2 + i), 8'h00});
    endtask

    task automatic push_cfg();
        exp_q.push_back(16'h0D02);
        exp_q.push_back(16'h1053);
        exp_q.push_back(16'h1150);
        exp_q.push_back(16'h1460);
    endtask

    task automatic wait_vld(input int target, input int budget, input string name);
        int c = 0;
        while (vld_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk_int(name, vld_cnt, target);
    endtask

    task automatic wait_txn(input int target, input int budget, input string name);
        int c = 0;
        while (txn_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk_int(name, txn_cnt, target);
    endtask

    task automatic wait_fall(input int target, input int budget, input string name);
        int c = 0;
        while (ss_falls < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk_int(name, ss_falls, target);
    endtask

    // Called right after rst drops at a negedge: first SS_n fall ~512 clk later.
    task automatic check_settle(input string name);
        int c = 0;
        while (SS_n !== 1'b0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (c < 509 || c > 515) begin
            n_fail++;
            $display("FAIL %s: got %0d clk expected 512 +/- 3", name, c);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int f;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            vecs[i].sensor.ptch = 16'h1234 + 16'(i);
            vecs[i].sensor.roll = 16'hFF80 + 16'(i);
            vecs[i].sensor.yaw  = 16'h8001 + 16'(i);
            vecs[i].sensor.ax   = 16'h0100 + 16'(i);
            vecs[i].sensor.ay   = 16'hFE00 + 16'(i);
            vecs[i].sensor.az   = 16'h4000 + 16'(i);
        end
        vecs[0].expect_out = '{ptch: 16'h1234, roll: -16'sd128, yaw: 16'h8001,
                               ax: 16'h0100, ay: 16'hFE00, az: 16'h4000};
        vecs[1].expect_out = '{ptch: 16'h1235, roll: -16'sd127, yaw: 16'h8002,
                               ax: 16'h0101, ay: 16'hFE01, az: 16'h4001};
        vecs[2].expect_out = '{ptch: 16'h1236, roll: -16'sd126, yaw: 16'h8003,
                               ax: 16'h0102, ay: 16'hFE02, az: 16'h4002};
        vecs[3].expect_out = '{ptch: 16'h1237, roll: -16'sd125, yaw: 16'h8004,
                               ax: 16'h0103, ay: 16'hFE03, az: 16'h4003};

        // Reset values
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n", 96'(SS_n), 96'(1));
        chk("rst_sclk", 96'(SCLK), 96'(1));
        chk("rst_mosi", 96'(MOSI), 96'(0));
        chk("rst_vld",  96'(vld),  96'(0));
        chk("rst_outs", dut_out(), 96'(0));

        // Settle and configuration writes
        push_cfg();
        rst = 1'b0;
        check_settle("settle_time");
        wait_txn(4, 5000, "cfg_writes");
        repeat (1500) @(negedge clk);
        chk_int("idle_no_txn", txn_cnt, 4);

        // Single sample set
        load_mem(vecs[0].sensor);
        push_cmds(NRD);
        exp_out_q.push_back(vecs[0].expect_out);
        f = ss_falls;
        INT = 1'b1;
        wait_fall(f + 1, 200, "int_starts_read");
        INT = 1'b0;
        wait_vld(1, 8000, "vld_first");
        chk_int("roll_signed", int'(roll_rt), -128);
        chk_int("yaw_signed", int'(yaw_rt), -32767);
        repeat (400) @(negedge clk);
        chk_int("reads_first", txn_cnt, 4 + NRD);

        // INT held high over three sample periods
        for (int i = 1; i < 4; i++) begin
            push_cmds(NRD);
            exp_out_q.push_back(vecs[i].expect_out);
        end
        load_mem(vecs[1].sensor);
        INT = 1'b1;
        wait_vld(2, 8000, "vld_burst1");
        load_mem(vecs[2].sensor);
        wait_vld(3, 8000, "vld_burst2");
        load_mem(vecs[3].sensor);
        f = ss_falls;
        wait_fall(f + 1, 200, "back_to_back_read");
        INT = 1'b0;
        wait_vld(4, 8000, "vld_burst3");
        repeat (400) @(negedge clk);
        chk_int("reads_burst", txn_cnt, 4 + 4 * NRD);

        // Reset in the middle of RD(5)
        load_mem(vecs[0].sensor);
        push_cmds(5);
        f = ss_falls;
        INT = 1'b1;
        wait_fall(f + 6, 6000, "reach_rd5");
        INT = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ss_n", 96'(SS_n), 96'(1));
        @(negedge clk);
        chk("abort_vld", 96'(vld), 96'(0));
        chk("abort_outs", dut_out(), 96'(0));
        chk("abort_sclk", 96'(SCLK), 96'(1));
        repeat (2) @(negedge clk);
        push_cfg();
        rst = 1'b0;
        check_settle("resettle_time");
        wait_txn(4 + 4 * NRD + 5 + 4, 5000, "recfg_writes");
        repeat (600) @(negedge clk);

        chk_int("vld_total", vld_cnt, 4);
        chk_int("cmd_q_empty", exp_q.size(), 0);
        chk_int("out_q_empty", exp_out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
